// File: rtl/instruction_decoder.sv
// Decode stage of the 8-bit microprocessor.
// Turns the instruction word from program memory into sequencer jump requests
// and datapath controls in the same cycle. Owns the zero flag and the
// saturating debug counters for retired instructions and taken jumps.
module instruction_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [7:0]       pm_data,
  input  logic             alu_zero,
  output logic             jmp,
  output logic             jmp_nz,
  output logic [3:0]       jmp_addr,
  output logic             dont_jmp,
  output logic [7:0]       reg_en,
  output logic [3:0]       src_sel,
  output logic [3:0]       imm,
  output logic [3:0]       alu_func,
  output logic             alu_b_sel,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] jump_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0] SRC_IMM = 4'd8;
  localparam logic [3:0] SRC_ALU = 4'd9;

  logic             z_reg;
  logic [CNT_W-1:0] instr_cnt_reg;
  logic [CNT_W-1:0] jump_cnt_reg;

  logic [2:0] dest;
  logic       reg_write;
  logic       is_alu;
  logic       jump_taken;

  // Instruction decode: purely combinational, everything quiet while in reset.
  always_comb begin
    jmp       = 1'b0;
    jmp_nz    = 1'b0;
    jmp_addr  = 4'd0;
    src_sel   = 4'd0;
    imm       = 4'd0;
    alu_func  = 4'd0;
    alu_b_sel = 1'b0;
    dest      = 3'd0;
    reg_write = 1'b0;
    is_alu    = 1'b0;
    if (!sync_reset) begin
      // Operand fields are passed through for every class; consumers ignore
      // them unless the class uses them.
      jmp_addr  = pm_data[3:0];
      imm       = pm_data[3:0];
      alu_func  = pm_data[3:0];
      alu_b_sel = pm_data[4];
      if (!pm_data[7]) begin
        // LOAD immediate into r[6:4]
        dest      = pm_data[6:4];
        reg_write = 1'b1;
        src_sel   = SRC_IMM;
      end else if (!pm_data[6]) begin
        // MOV r[5:3] <- r[2:0]; a self-move is a NOP with no write
        dest      = pm_data[5:3];
        src_sel   = {1'b0, pm_data[2:0]};
        reg_write = (pm_data[5:3] != pm_data[2:0]);
      end else if (!pm_data[5]) begin
        // ALU op, result always lands in register 4
        dest      = 3'd4;
        reg_write = 1'b1;
        src_sel   = SRC_ALU;
        is_alu    = 1'b1;
      end else if (!pm_data[4]) begin
        jmp       = 1'b1;
      end else begin
        jmp_nz    = 1'b1;
      end
    end
  end

  // One-hot write enable for the destination register.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg_en
      assign reg_en[gi] = reg_write && (dest == 3'(gi));
    end
  endgenerate

  // A conditional jump is only taken when the flag does not suppress it.
  assign jump_taken = jmp | (jmp_nz & ~z_reg);

  // Zero flag and saturating debug counters.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      z_reg         <= 1'b0;
      instr_cnt_reg <= '0;
      jump_cnt_reg  <= '0;
    end else begin
      if (is_alu)
        z_reg <= alu_zero;
      if (instr_cnt_reg != CNT_MAX)
        instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
      if (jump_taken && (jump_cnt_reg != CNT_MAX))
        jump_cnt_reg <= jump_cnt_reg + CNT_W'(1);
    end
  end

  assign dont_jmp    = z_reg;
  assign instr_count = instr_cnt_reg;
  assign jump_count  = jump_cnt_reg;

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
Decode stage of the 8-bit microprocessor. It sits between program memory and the program sequencer. It takes the instruction word that program memory returns for the current pc. It drives the sequencer's jmp, jmp_nz, jmp_addr and dont_jmp inputs, and drives the datapath's register-write enables, source select and ALU function. It owns the zero-flag register, plus saturating retired-instruction and taken-jump counters for debug.

Parameters:
CNT_W, 16, width of the instr_count and jump_count debug counters (8..32)

Ports:
clk  in  1  system clock, all state on rising edge
sync_reset  in  1  synchronous, active-high reset
pm_data  in  8  instruction word from program memory for the current pc
alu_zero  in  1  ALU result is zero for the instruction currently in pm_data
jmp  out  1  unconditional jump request to program sequencer
jmp_nz  out  1  jump-if-not-zero request to program sequencer
jmp_addr  out  4  jump target high nibble; sequencer forms {jmp_addr,4'h0}
dont_jmp  out  1  registered zero flag; 1 = suppress jmp_nz
reg_en  out  8  one-hot register write enable, index = destination 0..7
src_sel  out  4  datapath source: 0..7 = register index, 8 = immediate, 9 = ALU result
imm  out  4  immediate operand, pm_data[3:0]
alu_func  out  4  ALU function code, pm_data[3:0]
alu_b_sel  out  1  ALU second operand select, pm_data[4]
instr_count  out  CNT_W  retired instructions since reset, saturating
jump_count  out  CNT_W  taken jumps since reset, saturating

Behaviour:
Encoding, decode fully combinational from pm_data (zero added latency, same cycle as the sequencer computes pm_addr):
- 0ddd_iiii  LOAD: reg_en[ddd]=1, src_sel=8, imm=iiii
- 10dd_dsss  MOV: reg_en[ddd]=1, src_sel=sss. If ddd==sss: NOP, reg_en=0.
- 110b_ffff  ALU: reg_en[4]=1 (result reg r), src_sel=9, alu_b_sel=b, alu_func=ffff, flag update
- 1110_aaaa  JMP: jmp=1, jmp_addr=aaaa
- 1111_aaaa  JNZ: jmp_nz=1, jmp_addr=aaaa
- Non-jump instructions: jmp=jmp_nz=0.
- jmp_addr=pm_data[3:0] at all times outside reset; it is ignored by the sequencer unless a jump is asserted.
- Only one of jmp/jmp_nz/reg_en bits active per cycle.

While sync_reset=1:
- All combinational outputs forced to 0: jmp, jmp_nz, jmp_addr, reg_en, src_sel, imm, alu_func, alu_b_sel.
- The NOP-like forcing is required; the sequencer is already holding pm_addr=0.

Zero flag (z):
- Reset value 0.
- On a clock edge where the current instruction is ALU: z <= alu_zero.
- Otherwise z holds.
- dont_jmp = z, registered.
- A JNZ immediately after an ALU op therefore sees that op's result.
- An ALU op and a JNZ never coexist in the same cycle.

instr_count:
- Reset 0.
- +1 on every clock edge with sync_reset=0. NOP counts.
- Saturates at all-ones, no wrap.

jump_count:
- Reset 0.
- +1 on an edge where jmp=1, or where jmp_nz=1 and dont_jmp=0.
- Saturates at all-ones.

Reset mid-program:
- z, instr_count and jump_count clear on the same edge that sync_reset is sampled high.
- The decode outputs drop to 0 in that cycle.

Unused bits are don't-care:
- alu_func/imm reflect pm_data[3:0] whenever not in reset, for every class.
- alu_b_sel reflects pm_data[4] whenever not in reset.

Test Plan:
1. Hold sync_reset=1 with pm_data=8'hE5 -> jmp=0, jmp_addr=0, reg_en=0, dont_jmp=0, counters 0. Release -> same cycle jmp=1, jmp_addr=4'h5.
2. pm_data=8'h3A -> reg_en=8'h08, src_sel=8, imm=4'hA. pm_data=8'h9A (MOV 3<-2) -> reg_en=8'h08, src_sel=2. pm_data=8'h9B (MOV 3<-3) -> reg_en=0.
3. ALU 8'hC7 with alu_zero=1 for one cycle, then JNZ 8'hF2 -> dont_jmp=1, jmp_nz=1, jump_count unchanged. Repeat with alu_zero=0 -> dont_jmp=0, jump_count +1.
4. ALU with alu_zero=1, then LOAD/MOV/JMP for 3 cycles -> dont_jmp stays 1 throughout. Next ALU with alu_zero=0 -> dont_jmp=0 next cycle.
5. Set CNT_W=8 and run 300 unreset cycles of JMP 8'hE0 -> instr_count=jump_count=8'hFF and held.
6. Assert sync_reset for one cycle mid-run with z=1 and counts nonzero -> after the edge z=0, dont_jmp=0, both counts 0, then counting resumes from 1.
